// File: rtl/ru_seq.sv
// Rotation-unit job sequencer: runs 1..2^LEN_W-1 complex samples through the RU, one at a time.
// Element 0 goes in vectoring mode and the rest in rotation mode. Each RU op is guarded by a finish timeout.
module ru_seq #(
   parameter int DATA_W  = 12,
   parameter int LEN_W   = 3,
   parameter int TIMEOUT = 31
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic [LEN_W-1:0]         i_len,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   input  logic signed [DATA_W-1:0] i_real,
   input  logic signed [DATA_W-1:0] i_imag,
   output logic                     o_ru_trig,
   output logic signed [DATA_W-1:0] o_ru_real_y,
   output logic signed [DATA_W-1:0] o_ru_imag_y,
   output logic                     o_ru_mode_y,
   input  logic signed [DATA_W-1:0] i_ru_real_x,
   input  logic signed [DATA_W-1:0] i_ru_imag_x,
   input  logic                     i_ru_finish,
   output logic                     o_out_valid,
   output logic signed [DATA_W-1:0] o_real,
   output logic signed [DATA_W-1:0] o_imag,
   output logic                     o_last,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_err,
   output logic [2:0]               o_state_dbg
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT_IN = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT_RU = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t                     state_q, state_d;
   logic [LEN_W-1:0]           len_q, len_d;
   logic [LEN_W-1:0]           cnt_q, cnt_d;
   logic [TMO_W-1:0]           tmo_q, tmo_d;
   logic signed [DATA_W-1:0]   op_re_q, op_re_d, op_im_q, op_im_d;
   logic signed [DATA_W-1:0]   res_re_q, res_re_d, res_im_q, res_im_d;
   logic                       mode_q, mode_d;
   logic                       out_valid_q, out_valid_d;
   logic                       last_q, last_d;
   logic                       err_q, err_d;
   // Set by reset so a finish left over from an abandoned job is not flagged.
   logic                       stale_q, stale_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         op_re_q     <= '0;
         op_im_q     <= '0;
         res_re_q    <= '0;
         res_im_q    <= '0;
         mode_q      <= 1'b0;
         out_valid_q <= 1'b0;
         last_q      <= 1'b0;
         err_q       <= 1'b0;
         stale_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         op_re_q     <= op_re_d;
         op_im_q     <= op_im_d;
         res_re_q    <= res_re_d;
         res_im_q    <= res_im_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         last_q      <= last_d;
         err_q       <= err_d;
         stale_q     <= stale_d;
      end
   end

   // Input handshake: o_in_ready is high for the whole of WAIT_IN; an element transfers
   // on the rising edge where i_in_valid and o_in_ready are both high.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      op_re_d     = op_re_q;
      op_im_d     = op_im_q;
      res_re_d    = res_re_q;
      res_im_d    = res_im_q;
      mode_d      = mode_q;
      out_valid_d = 1'b0;
      last_d      = 1'b0;
      err_d       = err_q;
      stale_d     = stale_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               if (i_len != '0) begin
                  len_d   = i_len;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  stale_d = 1'b0;
                  state_d = S_WAIT_IN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_WAIT_IN: begin
            if (i_in_valid) begin
               op_re_d = i_real;
               op_im_d = i_imag;
               mode_d  = (cnt_q == '0);
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tmo_d   = '0;
            state_d = S_WAIT_RU;
         end
         S_WAIT_RU: begin
            tmo_d = tmo_q + TMO_W'(1);
            // A finish arriving on the expiry cycle still counts as a normal completion.
            if (i_ru_finish) begin
               res_re_d    = i_ru_real_x;
               res_im_d    = i_ru_imag_x;
               out_valid_d = 1'b1;
               last_d      = (cnt_q == len_q - LEN_W'(1));
               cnt_d       = cnt_q + LEN_W'(1);
               state_d     = (cnt_q == len_q - LEN_W'(1)) ? S_DONE : S_WAIT_IN;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (i_ru_finish && (state_q != S_WAIT_RU) && !stale_q) begin
         err_d = 1'b1;
      end
   end

   assign o_in_ready  = (state_q == S_WAIT_IN);
   assign o_ru_trig   = (state_q == S_ISSUE);
   assign o_busy      = (state_q != S_IDLE);
   assign o_done      = (state_q == S_DONE);
   assign o_ru_real_y = op_re_q;
   assign o_ru_imag_y = op_im_q;
   assign o_ru_mode_y = mode_q;
   assign o_out_valid = out_valid_q;
   assign o_last      = last_q;
   assign o_real      = res_re_q;
   assign o_imag      = res_im_q;
   assign o_err       = err_q;
   assign o_state_dbg = state_q;

endmodule

// File: tb/tb_ru_seq.sv
// Bench for ru_seq: directed scenarios plus random jobs, with a small RU responder model
// and a scoreboard of expected RU operands and sequencer outputs.
module tb_ru_seq;

   localparam int DW = 12;
   localparam int LW = 3;
   localparam int TO = 31;
   localparam int W  = 2 * DW + 1;

   logic          i_clk;
   logic          i_rst_n;
   logic          i_start;
   logic [LW-1:0] i_len;
   logic          i_in_valid;
   logic          o_in_ready;
   logic [DW-1:0] i_real, i_imag;
   logic          o_ru_trig;
   logic [DW-1:0] o_ru_real_y, o_ru_imag_y;
   logic          o_ru_mode_y;
   logic [DW-1:0] i_ru_real_x = '0;
   logic [DW-1:0] i_ru_imag_x = '0;
   logic          i_ru_finish;
   logic          o_out_valid;
   logic [DW-1:0] o_real, o_imag;
   logic          o_last, o_busy, o_done, o_err;
   logic [2:0]    o_state_dbg;

   logic          fin_auto = 1'b0;
   logic          fin_inj;
   assign i_ru_finish = fin_auto | fin_inj;

   ru_seq #(.DATA_W(DW), .LEN_W(LW), .TIMEOUT(TO)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_len       (i_len),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_real      (i_real),
      .i_imag      (i_imag),
      .o_ru_trig   (o_ru_trig),
      .o_ru_real_y (o_ru_real_y),
      .o_ru_imag_y (o_ru_imag_y),
      .o_ru_mode_y (o_ru_mode_y),
      .i_ru_real_x (i_ru_real_x),
      .i_ru_imag_x (i_ru_imag_x),
      .i_ru_finish (i_ru_finish),
      .o_out_valid (o_out_valid),
      .o_real      (o_real),
      .o_imag      (o_imag),
      .o_last      (o_last),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err),
      .o_state_dbg (o_state_dbg)
   );

   // ---------------- clock ----------------
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [W-1:0]  exp_q[$];     // {last, real_x, imag_x} per expected output
   logic [W-1:0]  exp_op_q[$];  // {mode, real_y, imag_y} per expected trigger
   int            trig_cnt = 0, out_cnt = 0, last_cnt = 0, done_cnt = 0;
   int            ru_lat = 16;  // -1: RU never finishes
   bit            ru_pend = 1'b0;
   int            ru_cd = 0;
   time           t_hs = 0, t_out = 0;

   int re_tab[3] = '{100, 7, -1};
   int im_tab[3] = '{-50, 7, 0};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural RU: vectoring returns (re+im, re-im), rotation turns the sample by -90 degrees.
   function automatic logic [2*DW-1:0] ru_fn(input logic [DW-1:0] re, input logic [DW-1:0] im,
                                             input logic mode);
      logic [DW-1:0] a, b;
      if (mode) begin
         a = re + im;
         b = re - im;
      end else begin
         a = im;
         b = DW'(0) - re;
      end
      return {a, b};
   endfunction

   // ---------------- RU responder and output monitor ----------------
   always @(negedge i_clk) begin
      logic [W-1:0] e;
      fin_auto = 1'b0;
      if (ru_pend) begin
         if (ru_cd == 0) begin
            fin_auto = 1'b1;
            ru_pend  = 1'b0;
         end else begin
            ru_cd = ru_cd - 1;
         end
      end
      if (o_ru_trig) begin
         trig_cnt++;
         if (exp_op_q.size() == 0) begin
            check("unexpected_trig", o_ru_trig, 1'b0);
         end else begin
            e = exp_op_q.pop_front();
            check("trig_mode", o_ru_mode_y, e[2*DW]);
            check("trig_real_y", o_ru_real_y, e[2*DW-1:DW]);
            check("trig_imag_y", o_ru_imag_y, e[DW-1:0]);
         end
         if (ru_lat >= 0) begin
            ru_pend = 1'b1;
            ru_cd   = ru_lat;
            {i_ru_real_x, i_ru_imag_x} = ru_fn(o_ru_real_y, o_ru_imag_y, o_ru_mode_y);
         end
      end
      if (o_out_valid) begin
         out_cnt++;
         t_out = $time;
         if (exp_q.size() == 0) begin
            check("unexpected_out", o_out_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("out_last", o_last, e[2*DW]);
            check("out_real", o_real, e[2*DW-1:DW]);
            check("out_imag", o_imag, e[DW-1:0]);
         end
      end
      if (o_last) begin
         last_cnt++;
         check("last_with_valid", o_out_valid, 1'b1);
      end
      if (o_done) done_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge i_clk);
      #1;
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_in_ready"}, o_in_ready, 1'b0);
      check({tag, "_trig"}, o_ru_trig, 1'b0);
      check({tag, "_out_valid"}, o_out_valid, 1'b0);
      check({tag, "_last"}, o_last, 1'b0);
      check({tag, "_busy"}, o_busy, 1'b0);
      check({tag, "_done"}, o_done, 1'b0);
      check({tag, "_err"}, o_err, 1'b0);
      check({tag, "_mode"}, o_ru_mode_y, 1'b0);
      check({tag, "_real"}, o_real, '0);
      check({tag, "_imag"}, o_imag, '0);
      check({tag, "_real_y"}, o_ru_real_y, '0);
      check({tag, "_imag_y"}, o_ru_imag_y, '0);
   endtask

   task automatic start_job(input int len);
      i_start = 1'b1;
      i_len   = LW'(len);
      step();
      i_start = 1'b0;
   endtask

   task automatic send_elem(input logic [DW-1:0] re, input logic [DW-1:0] im,
                            input int idx, input int len);
      int n = 0;
      while (!o_in_ready && n < 200) begin
         step();
         n++;
      end
      check("in_ready_wait", o_in_ready, 1'b1);
      exp_op_q.push_back({idx == 0, re, im});
      exp_q.push_back({idx == len - 1, ru_fn(re, im, idx == 0)});
      i_in_valid = 1'b1;
      i_real     = re;
      i_imag     = im;
      t_hs       = $time;
      step();
      i_in_valid = 1'b0;
      i_real     = DW'($urandom);
      i_imag     = DW'($urandom);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!o_done && n < budget) begin
         step();
         n++;
      end
      check("done_seen", o_done, 1'b1);
   endtask

   task automatic run_job(input int len, input bit use_tab);
      int d0 = done_cnt;
      int o0 = out_cnt;
      int l0 = last_cnt;
      logic [DW-1:0] re, im;
      start_job(len);
      check("job_busy", o_busy, 1'b1);
      check("job_err_clr", o_err, 1'b0);
      for (int i = 0; i < len; i++) begin
         re = use_tab ? DW'(re_tab[i]) : DW'($urandom);
         im = use_tab ? DW'(im_tab[i]) : DW'($urandom);
         send_elem(re, im, i, len);
      end
      wait_done(len * 40 + 40);
      step();
      check("job_outs", out_cnt - o0, len);
      check("job_last", last_cnt - l0, 1);
      check("job_done", done_cnt - d0, 1);
      check("job_err", o_err, 1'b0);
      check("job_idle", o_busy, 1'b0);
      check("job_sb_empty", exp_q.size(), 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int o0, d0, t0;
      i_rst_n = 1'b0; i_start = 1'b0; i_len = '0; i_in_valid = 1'b0;
      i_real = '0; i_imag = '0; fin_inj = 1'b0;
      repeat (3) step();
      check_reset_outs("rst");
      i_rst_n = 1'b1;
      step();

      // three-element job with fixed samples, slow RU
      ru_lat = 16;
      run_job(3, 1'b1);

      // zero length is rejected, then a one-element job clears the error
      start_job(0);
      check("len0_err", o_err, 1'b1);
      check("len0_busy", o_busy, 1'b0);
      step();
      check("len0_still_idle", o_busy, 1'b0);
      run_job(1, 1'b0);

      // minimum latency with an immediate RU
      ru_lat = 0;
      run_job(1, 1'b0);
      check("min_latency", (t_out - t_hs + 1) / 10, 3);

      // random jobs
      for (int j = 0; j < 5; j++) begin
         ru_lat = $urandom_range(0, 8);
         run_job($urandom_range(1, 7), 1'b0);
      end

      // RU never finishes: timeout
      ru_lat = -1;
      o0 = out_cnt;
      start_job(2);
      send_elem(DW'($urandom), DW'($urandom), 0, 2);
      check("to_trig", o_ru_trig, 1'b1);
      repeat (31) step();
      check("to_err_early", o_err, 1'b0);
      step();
      check("to_err", o_err, 1'b1);
      check("to_done", o_done, 1'b1);
      exp_q.delete();
      step();
      check("to_no_out", out_cnt - o0, 0);
      check("to_idle", o_busy, 1'b0);
      check("to_err_sticky", o_err, 1'b1);

      // finish lands on the expiry cycle: normal completion
      ru_lat = 30;
      run_job(1, 1'b0);

      // finish while idle
      o0 = out_cnt;
      fin_inj = 1'b1;
      step();
      fin_inj = 1'b0;
      check("idle_fin_err", o_err, 1'b1);
      step();
      check("idle_fin_no_out", out_cnt - o0, 0);

      // reset during WAIT_RU of element 2 of 4
      ru_lat = 16;
      d0 = done_cnt;
      start_job(4);
      send_elem(DW'($urandom), DW'($urandom), 0, 4);
      send_elem(DW'($urandom), DW'($urandom), 1, 4);
      repeat (3) step();
      check("pre_rst_busy", o_busy, 1'b1);
      i_rst_n = 1'b0;
      #1;
      check_reset_outs("midrst");
      step();
      check_reset_outs("midrst_hold");
      i_rst_n = 1'b1;
      exp_q.delete();
      exp_op_q.delete();
      o0 = out_cnt;
      repeat (25) step();
      check("stale_no_err", o_err, 1'b0);
      check("stale_no_out", out_cnt - o0, 0);
      check("rst_no_done", done_cnt - d0, 0);
      run_job(2, 1'b0);

      // input stalls for 10 cycles with a stray start mid-job
      ru_lat = 5;
      o0 = out_cnt;
      d0 = done_cnt;
      start_job(2);
      t0 = trig_cnt;
      for (int k = 0; k < 10; k++) begin
         i_start = (k == 5);
         i_len   = LW'(5);
         step();
         check("stall_ready", o_in_ready, 1'b1);
      end
      i_start = 1'b0;
      check("stall_no_trig", trig_cnt - t0, 0);
      send_elem(DW'($urandom), DW'($urandom), 0, 2);
      send_elem(DW'($urandom), DW'($urandom), 1, 2);
      wait_done(120);
      step();
      check("stall_outs", out_cnt - o0, 2);
      check("stall_done", done_cnt - d0, 1);
      check("stall_sb_empty", exp_q.size(), 0);
      check("stall_err", o_err, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
